// File: rtl/vbfs_scatter_ctrl_if.sv
// vbfs_scatter_ctrl_if
//   Bundles the three channels of the scatter sequencer:
//     update_* : incoming vertex update (valid/ready handshake)
//     mem_*    : neighbor memory read port (data returns 1 cycle after strobe)
//     msg_*    : outgoing neighbor/barrier message (valid/ack handshake)
//   Modports:
//     slave  : view taken by the sequencer itself
//     master : view taken by the surrounding environment (producer, memory, consumer)
interface vbfs_scatter_ctrl_if #(
    parameter int ADDR_WIDTH = 16
);
    logic                  update_valid;
    logic                  update_ready;
    logic [31:0]           update_sender;
    logic [31:0]           update_num_neighbors;
    logic [ADDR_WIDTH-1:0] update_base;
    logic [1:0]            update_round;
    logic                  update_barrier;

    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_data;

    logic                  msg_valid;
    logic                  msg_ack;
    logic [31:0]           msg_neighbor;
    logic [31:0]           msg_sender;
    logic [1:0]            msg_round;
    logic                  msg_barrier;

    modport slave (
        input  update_valid, update_sender, update_num_neighbors,
               update_base, update_round, update_barrier,
        output update_ready,
        output mem_rd_en, mem_addr,
        input  mem_data,
        output msg_valid, msg_neighbor, msg_sender, msg_round, msg_barrier,
        input  msg_ack
    );

    modport master (
        output update_valid, update_sender, update_num_neighbors,
               update_base, update_round, update_barrier,
        input  update_ready,
        input  mem_rd_en, mem_addr,
        output mem_data,
        input  msg_valid, msg_neighbor, msg_sender, msg_round, msg_barrier,
        output msg_ack
    );
endinterface

// File: rtl/vbfs_scatter_ctrl.sv
// vbfs_scatter_ctrl
//   Accepts one update per vertex, walks its adjacency list in neighbor
//   memory and emits one message per neighbor, in order. Barrier tokens
//   travel the same ordered output path behind all earlier messages.
//   Ports:
//     sys_clk   : rising-edge clock
//     sys_rst_n : asynchronous active-low reset
//     bus       : update / neighbor-memory / message channels (slave view)
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | update_ready high, waiting for an update
//   FETCH   | issuing adjacency reads while output credit allows
//   BARRIER | waiting for reads to land, then queuing a barrier entry
module vbfs_scatter_ctrl #(
    parameter int ADDR_WIDTH = 16
) (
    input logic               sys_clk,
    input logic               sys_rst_n,
    vbfs_scatter_ctrl_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_BARRIER} state_t;

    typedef struct packed {
        logic [31:0] neighbor;
        logic [31:0] sender;
        logic [1:0]  round;
        logic        barrier;
    } entry_t;

    state_t                state, state_n;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           remaining_q;
    logic [31:0]           sender_q;
    logic [1:0]            round_q;
    logic                  ready_q;

    logic                  rd_pend_q;
    logic [31:0]           pend_sender_q;
    logic [1:0]            pend_round_q;

    entry_t                out_q, skid_q, push_e;
    logic                  out_v_q, skid_v_q;

    logic                  accept, pop, credit_ok, issue, push_barrier, push;
    logic [1:0]            occupancy;

    assign accept    = bus.update_valid && ready_q;
    assign pop       = out_v_q && bus.msg_ack;
    // Entries that will still hold a slot after this edge; the pop term lets
    // a consumed entry's slot be reused in the same cycle.
    assign occupancy = 2'(out_v_q) + 2'(skid_v_q) + 2'(rd_pend_q) - 2'(pop);
    assign credit_ok = occupancy < 2'd2;
    assign push      = rd_pend_q || push_barrier;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= S_IDLE;
        else            state <= state_n;
    end

    always_comb begin
        state_n      = state;
        issue        = 1'b0;
        push_barrier = 1'b0;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (bus.update_barrier)                  state_n = S_BARRIER;
                    else if (bus.update_num_neighbors != '0) state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                if (credit_ok) begin
                    issue = 1'b1;
                    if (remaining_q == 32'd1) state_n = S_IDLE;
                end
            end
            S_BARRIER: begin
                if (!rd_pend_q && credit_ok) begin
                    push_barrier = 1'b1;
                    state_n      = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Read data can never coincide with a barrier push: the barrier waits for
    // the read pipe to be empty.
    always_comb begin
        push_e = '0;
        if (rd_pend_q) begin
            push_e.neighbor = bus.mem_data;
            push_e.sender   = pend_sender_q;
            push_e.round    = pend_round_q;
        end else begin
            push_e.sender   = sender_q;
            push_e.round    = round_q;
            push_e.barrier  = 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            ready_q       <= 1'b0;
            addr_q        <= '0;
            remaining_q   <= '0;
            sender_q      <= '0;
            round_q       <= '0;
            rd_pend_q     <= 1'b0;
            pend_sender_q <= '0;
            pend_round_q  <= '0;
        end else begin
            ready_q   <= (state_n == S_IDLE);
            rd_pend_q <= issue;
            if (accept) begin
                sender_q    <= bus.update_sender;
                round_q     <= bus.update_round;
                addr_q      <= bus.update_base;
                remaining_q <= bus.update_num_neighbors;
            end else if (issue) begin
                addr_q      <= addr_q + ADDR_WIDTH'(1);
                remaining_q <= remaining_q - 32'd1;
            end
            if (issue) begin
                pend_sender_q <= sender_q;
                pend_round_q  <= round_q;
            end
        end
    end

    // Output register backed by a one-entry skid; the skid always drains
    // into the output register before any newer entry.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            out_q    <= '0;
            out_v_q  <= 1'b0;
            skid_q   <= '0;
            skid_v_q <= 1'b0;
        end else if (!out_v_q || pop) begin
            if (skid_v_q) begin
                out_q   <= skid_q;
                out_v_q <= 1'b1;
                if (push) skid_q <= push_e;
                else      skid_v_q <= 1'b0;
            end else if (push) begin
                out_q   <= push_e;
                out_v_q <= 1'b1;
            end else begin
                out_v_q <= 1'b0;
            end
        end else if (push) begin
            skid_q   <= push_e;
            skid_v_q <= 1'b1;
        end
    end

    assign bus.update_ready = ready_q;
    assign bus.mem_rd_en    = issue;
    assign bus.mem_addr     = addr_q;
    assign bus.msg_valid    = out_v_q;
    assign bus.msg_neighbor = out_q.neighbor;
    assign bus.msg_sender   = out_q.sender;
    assign bus.msg_round    = out_q.round;
    assign bus.msg_barrier  = out_q.barrier;

endmodule
